// File: rtl/pm_pkg.sv
// Shared types and helpers for the pm_arb grant arbiter and its picker.
package pm_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } pm_state_e;

    localparam logic PM_FIXED = 1'b0;
    localparam logic PM_RR    = 1'b1;

    // Index width for an N-entry vector; never narrower than one bit.
    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pm_arb_if.sv
// Requester-side bundle of pm_arb: request/done inputs and registered grant outputs.
interface pm_arb_if #(
    parameter int N_CH = 4
);
    localparam int ID_W = pm_pkg::id_w(N_CH);

    logic            en;
    logic            mode;
    logic [N_CH-1:0] req;
    logic [N_CH-1:0] done;
    logic [N_CH-1:0] grant;
    logic [ID_W-1:0] grant_id;
    logic            busy;
    logic            timeout;

    modport master (
        output en, mode, req, done,
        input  grant, grant_id, busy, timeout
    );

    modport slave (
        input  en, mode, req, done,
        output grant, grant_id, busy, timeout
    );

endinterface

// File: rtl/pm_rr_pick.sv
// Combinational winner picker: rotate requests by the start index, take the
// lowest set bit, rotate the result back. Fixed priority uses a start index of 0.
module pm_rr_pick
    import pm_pkg::*;
#(
    parameter int N_CH = 4,
    parameter int ID_W = id_w(N_CH)
) (
    input  logic [N_CH-1:0] req,
    input  logic [ID_W-1:0] rr_ptr,
    input  logic            mode,
    output logic [N_CH-1:0] win,
    output logic [ID_W-1:0] win_idx,
    output logic            valid
);

    logic [ID_W-1:0] base;
    logic [N_CH-1:0] rot;
    logic [ID_W-1:0] off;
    logic [ID_W:0]   sum;

    // NOTE: every signal driven here gets a value on every path before any
    // conditional update, otherwise synthesis would infer latches.
    always_comb begin
        base = (mode == PM_RR) ? rr_ptr : '0;
        rot  = N_CH'({req, req} >> base);

        off = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (rot[i]) off = ID_W'(i);
        end

        sum = {1'b0, off} + {1'b0, base};
        if (sum >= (ID_W + 1)'(N_CH)) sum = sum - (ID_W + 1)'(N_CH);

        win_idx = sum[ID_W-1:0];
        valid   = |req;
        win     = valid ? (N_CH'(1) << win_idx) : '0;
    end

endmodule

// File: rtl/pm_arb.sv
// N-channel grant arbiter: fixed-priority or round-robin pick in IDLE, grant held
// until done, request drop or hold timeout, then a one-cycle RELEASE gap.
module pm_arb
    import pm_pkg::*;
#(
    parameter int N_CH    = 4,
    parameter int TO_W    = 4,
    parameter int TIMEOUT = 15
) (
    input logic     clk,
    input logic     rst_n,
    pm_arb_if.slave bus
);

    localparam int              ID_W   = id_w(N_CH);
    localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT);

    if (TIMEOUT < 1 || TIMEOUT > (2 ** TO_W) - 1) begin : g_bad_timeout
        $error("pm_arb: TIMEOUT must lie in 1..2**TO_W-1");
    end
    if (N_CH < 2 || N_CH > 16) begin : g_bad_nch
        $error("pm_arb: N_CH must lie in 2..16");
    end

    pm_state_e       state;
    logic [N_CH-1:0] grant_q;
    logic [ID_W-1:0] grant_id_q;
    logic            busy_q;
    logic            timeout_q;
    logic [TO_W-1:0] cnt;
    logic [ID_W-1:0] rr_ptr;

    logic [N_CH-1:0] pick_win;
    logic [ID_W-1:0] pick_idx;
    logic            pick_valid;
    logic [ID_W-1:0] ptr_next;
    logic            done_g;
    logic            req_g;

    pm_rr_pick #(.N_CH(N_CH), .ID_W(ID_W)) u_pick (
        .req     (bus.req),
        .rr_ptr  (rr_ptr),
        .mode    (bus.mode),
        .win     (pick_win),
        .win_idx (pick_idx),
        .valid   (pick_valid)
    );

    // Only the owner's done/req matter; other channels are masked out here.
    assign done_g   = |(bus.done & grant_q);
    assign req_g    = |(bus.req & grant_q);
    assign ptr_next = (pick_idx == ID_W'(N_CH - 1)) ? '0 : pick_idx + ID_W'(1);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            grant_q    <= '0;
            grant_id_q <= '0;
            busy_q     <= 1'b0;
            timeout_q  <= 1'b0;
            cnt        <= '0;
            rr_ptr     <= '0;
        end else begin
            timeout_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.en && pick_valid) begin
                        state      <= GRANT;
                        grant_q    <= pick_win;
                        grant_id_q <= pick_idx;
                        busy_q     <= 1'b1;
                        cnt        <= TO_W'(1);
                        if (bus.mode == PM_RR) rr_ptr <= ptr_next;
                    end
                end
                GRANT: begin
                    if (done_g || !req_g || cnt == TO_LIM) begin
                        state      <= RELEASE;
                        grant_q    <= '0;
                        grant_id_q <= '0;
                        cnt        <= '0;
                        // Completion and abandonment outrank the timeout.
                        timeout_q  <= req_g && !done_g;
                    end else if (cnt != '1) begin
                        cnt <= cnt + TO_W'(1);
                    end
                end
                RELEASE: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
                default: begin
                    state      <= IDLE;
                    grant_q    <= '0;
                    grant_id_q <= '0;
                    busy_q     <= 1'b0;
                    cnt        <= '0;
                end
            endcase
        end
    end

    assign bus.grant    = grant_q;
    assign bus.grant_id = grant_id_q;
    assign bus.busy     = busy_q;
    assign bus.timeout  = timeout_q;

endmodule

// File: tb/tb_pm_arb.sv
// Scoreboard bench for pm_arb: stimulus queues expected grant/release events with
// their cycle stamps; a negedge monitor detects events and checks them in order.
module tb_pm_arb;

    localparam int N_CH    = 4;
    localparam int TO_W    = 4;
    localparam int TIMEOUT = 15;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   n_checks = 0;
    int   n_err    = 0;

    pm_arb_if #(.N_CH(N_CH)) ifc ();

    pm_arb #(.N_CH(N_CH), .TO_W(TO_W), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit is_rel;
        int id;
        bit to;
        int at;
    } ev_t;

    ev_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_grant(input int id, input int at);
        ev_t e;
        e.is_rel = 1'b0; e.id = id; e.to = 1'b0; e.at = at;
        exp_q.push_back(e);
    endtask

    task automatic push_rel(input bit to, input int at);
        ev_t e;
        e.is_rel = 1'b1; e.id = 0; e.to = to; e.at = at;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_to(input int target);
        while (cyc < target) tick();
    endtask

    // Monitor: a grant event is grant rising from zero; a release event is grant
    // falling to zero while busy stays high.
    logic [N_CH-1:0] prev_grant = '0;
    logic            new_g;
    logic            new_r;
    ev_t             got;

    always @(negedge clk) begin
        new_g = (ifc.grant != '0) && (prev_grant == '0);
        new_r = ifc.busy && (ifc.grant == '0) && (prev_grant != '0);
        check("grant_onehot", 32'($countones(ifc.grant) <= 1), 32'd1);
        if (prev_grant != '0 && ifc.grant != '0)
            check("grant_stable", 32'(ifc.grant), 32'(prev_grant));
        if (ifc.timeout)
            check("timeout_only_at_release", 32'(new_r), 32'd1);
        if (new_g || new_r) begin
            if (exp_q.size() == 0) begin
                check("unexpected_event", 32'(new_r), 32'd2);
            end else begin
                got = exp_q.pop_front();
                check("event_kind", 32'(new_r), 32'(got.is_rel));
                check("event_cycle", 32'(cyc), 32'(got.at));
                if (new_g) begin
                    check("grant_id", 32'(ifc.grant_id), 32'(got.id));
                    check("grant_vec", 32'(ifc.grant), 32'(1 << got.id));
                end else begin
                    check("release_timeout", 32'(ifc.timeout), 32'(got.to));
                    check("release_grant_id", 32'(ifc.grant_id), 32'd0);
                end
            end
        end
        prev_grant <= ifc.grant;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation ran past its time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    int c;
    int g;
    int ids[5];

    initial begin
        ifc.en   = 1'b1;
        ifc.mode = 1'b0;
        ifc.req  = 4'b1111;
        ifc.done = 4'b0000;

        // Reset values, then first grant one cycle after the first IDLE sample.
        tick(); tick();
        check("rst_grant", 32'(ifc.grant), 32'd0);
        check("rst_grant_id", 32'(ifc.grant_id), 32'd0);
        check("rst_busy", 32'(ifc.busy), 32'd0);
        check("rst_timeout", 32'(ifc.timeout), 32'd0);
        c = cyc;
        rst_n = 1'b1;
        push_grant(0, c + 1);
        tick_to(c + 2);
        rst_n = 1'b0;
        #1;
        check("async_rst_grant", 32'(ifc.grant), 32'd0);
        check("async_rst_busy", 32'(ifc.busy), 32'd0);
        ifc.req = 4'b0000;
        tick();
        rst_n = 1'b1;
        tick(); tick();

        // Fixed priority: channel 1 always wins over 3, grants 3 cycles apart.
        c = cyc;
        ifc.mode = 1'b0;
        ifc.req  = 4'b1010;
        push_grant(1, c + 1);
        g = c + 1;
        for (int i = 0; i < 3; i++) begin
            tick_to(g);
            ifc.done = 4'b0010;
            if (i == 2) ifc.req = 4'b0000;
            push_rel(1'b0, g + 1);
            if (i < 2) push_grant(1, g + 3);
            tick();
            ifc.done = 4'b0000;
            g += 3;
        end
        tick(); tick();

        // Round robin with all requests: 0,1,2,3,0.
        ids = '{0, 1, 2, 3, 0};
        c = cyc;
        ifc.mode = 1'b1;
        ifc.req  = 4'b1111;
        push_grant(ids[0], c + 1);
        g = c + 1;
        for (int i = 0; i < 5; i++) begin
            tick_to(g + 2);
            ifc.done = 4'(1 << ids[i]);
            if (i == 4) ifc.req = 4'b0000;
            push_rel(1'b0, g + 3);
            if (i < 4) push_grant(ids[i + 1], g + 5);
            tick();
            ifc.done = 4'b0000;
            g += 5;
        end
        tick(); tick();

        // Hold timeout: 15 grant cycles, forced release, then re-grant.
        c = cyc;
        ifc.mode = 1'b0;
        ifc.req  = 4'b0100;
        push_grant(2, c + 1);
        push_rel(1'b1, c + 16);
        push_grant(2, c + 18);
        tick_to(c + 18);
        ifc.req = 4'b0000;
        push_rel(1'b0, c + 19);
        tick_to(c + 21);

        // Owner drops req on grant cycle 3 while a foreign done pulses.
        c = cyc;
        ifc.req = 4'b0010;
        push_grant(1, c + 1);
        tick_to(c + 3);
        ifc.req  = 4'b0000;
        ifc.done = 4'b0001;
        push_rel(1'b0, c + 4);
        tick();
        ifc.done = 4'b0000;
        tick(); tick();

        // Disabled: no grant, not busy.
        ifc.en  = 1'b0;
        ifc.req = 4'b0011;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("disabled_busy", 32'(ifc.busy), 32'd0);
            check("disabled_grant", 32'(ifc.grant), 32'd0);
        end

        // Mode flipped mid-grant: current grant holds, next pick uses rr_ptr = 1.
        c = cyc;
        ifc.en = 1'b1;
        push_grant(0, c + 1);
        tick_to(c + 1);
        ifc.mode = 1'b1;
        tick_to(c + 2);
        ifc.done = 4'b0001;
        push_rel(1'b0, c + 3);
        push_grant(1, c + 5);
        tick();
        ifc.done = 4'b0000;
        tick_to(c + 5);
        ifc.req = 4'b0000;
        push_rel(1'b0, c + 6);
        tick_to(c + 9);

        check("pending_events", 32'(exp_q.size()), 32'd0);
        check("final_busy", 32'(ifc.busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/pm_arb.md
Name: pm_arb

Overview:
- Parametrised, registered successor to the team's combinational pm-style control decoders.
- Arbitrates N_CH request channels onto one shared resource.
- Selects either fixed-priority or round-robin mode at run time.
- Holds each grant until the owner signals done, drops its request, or a hold timeout expires.
- Sits between channel requesters and a single shared datapath or port.

Parameters:
N_CH, 4, number of request channels (2..16)
TO_W, 4, width of the hold-timeout counter
TIMEOUT, 15, grant cycles allowed before forced release (1..2^TO_W-1)

Ports:
clk  input  1  clock; all state on rising edge
rst_n  input  1  reset, asynchronous, active-low
en  input  1  arbitration enable; sampled only in IDLE
mode  input  1  0 = fixed priority (lowest index wins), 1 = round robin; sampled only in IDLE
req  input  N_CH  per-channel request level
done  input  N_CH  per-channel completion pulse
grant  output  N_CH  one-hot registered grant
grant_id  output  $clog2(N_CH)  index of granted channel; 0 when none
busy  output  1  high in GRANT and RELEASE
timeout  output  1  one-cycle pulse on forced release

Behaviour:
- Reset values (async, rst_n low): state = IDLE, grant = 0, grant_id = 0, busy = 0, timeout = 0, hold counter = 0, rr pointer = 0. Reset asserted mid-grant drops grant in the same cycle, asynchronously.
- States: IDLE, GRANT, RELEASE.
- IDLE:
  - If en and |req: pick a winner and go to GRANT. grant and grant_id are registered, so they are visible on the cycle after req is sampled (latency 1).
  - Otherwise stay in IDLE.
- Winner selection, mode 0: lowest set index of req.
- Winner selection, mode 1: first set index at or after rr_ptr, wrapping from N_CH-1 to 0.
  - On entering GRANT, rr_ptr becomes winner+1 mod N_CH.
  - rr_ptr is unchanged in mode 0.
- GRANT:
  - grant stays one-hot and stable. The hold counter increments every cycle, starting at 1 on the first GRANT cycle.
  - Exit priority when several conditions hit in the same cycle:
    1. done[g] high -> RELEASE (normal completion).
    2. req[g] low -> RELEASE (abandon, no timeout pulse).
    3. counter == TIMEOUT -> RELEASE with timeout = 1 in that next cycle.
  - done and req on non-granted channels are ignored.
  - en and mode changes are ignored until IDLE.
- RELEASE:
  - Exactly one cycle. grant = 0, grant_id = 0, busy = 1, counter cleared. Next state is IDLE.
  - Minimum spacing between grants: grant cycle(s), then RELEASE, then IDLE, then the new grant. So back-to-back grants are 3 cycles apart at minimum.
- Invariants:
  - grant is always zero or one-hot.
  - The counter saturates and never wraps: TIMEOUT ≤ 2^TO_W-1 is checked by an elaboration assertion.
  - timeout is high for exactly one cycle per forced release.
- Simultaneous events:
  - All req bits set in mode 1 yields a strict rotation 0,1,2,3,0.
  - done arriving on the same cycle the counter reaches TIMEOUT counts as normal completion, with no timeout pulse.

Decomposition:
- Shared package pm_pkg holds:
  - state enum pm_state_e {IDLE, GRANT, RELEASE}
  - localparam ID_W = $clog2(N_CH) helper function
  - mode constants PM_FIXED = 0, PM_RR = 1
- One sub-module, pm_rr_pick: purely combinational.
  - Inputs: req, rr_ptr, mode.
  - Outputs: one-hot winner and its index.
  - Uses a rotate / priority-encode / rotate-back structure.
- The FSM, counter and pointer registers stay in pm_arb.

Test Plan:
- Reset with req = 4'b1111, en = 1, then release rst_n -> grant = 4'b0001 one cycle after the first sampled IDLE; assert rst_n low mid-GRANT -> grant = 0 immediately.
- mode = 0, req = 4'b1010 held, done[1] pulsed each grant -> grant_id always 1, grants 3 cycles apart, channel 3 starves.
- mode = 1, req = 4'b1111, done pulsed 2 cycles after each grant -> grant_id sequence 0,1,2,3,0; rr_ptr wraps correctly.
- TIMEOUT = 15, req = 4'b0100 held, no done -> grant held 15 cycles, then RELEASE with timeout = 1 for one cycle, then re-grant to channel 2.
- Granted channel 1 drops req[1] on grant cycle 3 while done[0] pulses -> RELEASE next cycle, timeout = 0, done[0] ignored.
- en = 0 with req = 4'b0011 -> stays IDLE, busy = 0. Toggle mode mid-GRANT -> current grant unaffected; new mode applies on the next IDLE decision.
